fir_mac_sequencer: RTL

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

---
 rtl/fir_mac_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed FIR filter, one shared MAC, one tap per cycle.
// Optional build macro FIR_SATURATE_EN: clamp out-of-range results instead of wrapping.
module fir_mac_sequencer #(
   parameter int DATA_WIDTH = 24,
   parameter int NUM_TAPS   = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_s_valid,
   output logic                          o_s_ready,
   input  logic [DATA_WIDTH-1:0]         iv_s_data,
   input  logic                          i_coef_we,
   input  logic [$clog2(NUM_TAPS)-1:0]   iv_coef_addr,
   input  logic [DATA_WIDTH-1:0]         iv_coef_data,
   output logic                          o_m_valid,
   input  logic                          i_m_ready,
   output logic [DATA_WIDTH-1:0]         ov_m_data,
   output logic                          o_busy,
   output logic                          o_overflow
);

   localparam int AW     = $clog2(NUM_TAPS);
   localparam int ACC_W  = DATA_WIDTH + AW + 1;
   localparam int PROD_W = 2 * DATA_WIDTH;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MAC  = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

   localparam logic [AW:0]               LAST_CNT = (AW+1)'(NUM_TAPS);
   localparam logic [AW-1:0]             PTR_ONE  = AW'(1);
   localparam logic signed [ACC_W-1:0]   MAX_V    = ACC_W'((1 <<< (DATA_WIDTH-1)) - 1);
   localparam logic signed [ACC_W-1:0]   MIN_V    = ~MAX_V;

   logic [1:0]                    state;
   logic signed [DATA_WIDTH-1:0]  x_mem [NUM_TAPS];
   logic signed [DATA_WIDTH-1:0]  c_mem [NUM_TAPS];
   logic [AW-1:0]                 wr_ptr;
   logic [AW-1:0]                 base_ptr;
   logic [AW-1:0]                 tap;
   logic [AW-1:0]                 x_idx;
   logic [AW:0]                   cnt;
   logic signed [ACC_W-1:0]       acc;
   logic signed [ACC_W-1:0]       prod_q;
   logic signed [ACC_W-1:0]       acc_final;
   logic signed [PROD_W-1:0]      prod_full;
   logic signed [PROD_W-1:0]      prod_sh;
   logic                          overflow_now;
   logic [DATA_WIDTH-1:0]         result;
   logic [DATA_WIDTH-1:0]         data_q;
   logic                          ovf_q;

   // Product is registered, so the pipeline needs NUM_TAPS+1 cycles in MAC.
   assign tap       = cnt[AW-1:0];
   assign x_idx     = base_ptr - tap;
   assign prod_full = PROD_W'(c_mem[tap]) * PROD_W'(x_mem[x_idx]);
   assign prod_sh   = prod_full >>> (DATA_WIDTH - 1);
   assign acc_final = acc + prod_q;
   assign overflow_now = (acc_final > MAX_V) || (acc_final < MIN_V);

   always_comb begin
      result = acc_final[DATA_WIDTH-1:0];
`ifdef FIR_SATURATE_EN
      if (acc_final > MAX_V)
         result = MAX_V[DATA_WIDTH-1:0];
      else if (acc_final < MIN_V)
         result = MIN_V[DATA_WIDTH-1:0];
`else
      result = acc_final[DATA_WIDTH-1:0];
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         wr_ptr   <= '0;
         base_ptr <= '0;
         cnt      <= '0;
         acc      <= '0;
         prod_q   <= '0;
         data_q   <= '0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < NUM_TAPS; i++) begin
            x_mem[i] <= '0;
            c_mem[i] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_coef_we)
                  c_mem[iv_coef_addr] <= iv_coef_data;
               if (i_s_valid) begin
                  x_mem[wr_ptr] <= iv_s_data;
                  base_ptr      <= wr_ptr;
                  wr_ptr        <= wr_ptr + PTR_ONE;
                  acc           <= '0;
                  prod_q        <= '0;
                  cnt           <= '0;
                  state         <= ST_MAC;
               end
            end
            ST_MAC: begin
               if (cnt != LAST_CNT)
                  prod_q <= ACC_W'(prod_sh);
               acc <= acc_final;
               cnt <= cnt + 1'(1);
               if (cnt == LAST_CNT) begin
                  state  <= ST_OUT;
                  data_q <= result;
                  if (overflow_now)
                     ovf_q <= 1'b1;
               end
            end
            ST_OUT: begin
               if (i_m_ready)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_s_ready  = (state == ST_IDLE);
   assign o_m_valid  = (state == ST_OUT);
   assign o_busy     = (state != ST_IDLE);
   assign ov_m_data  = data_q;
   assign o_overflow = ovf_q;

endmodule
